gmii_rx_frame_ctrl: RTL

//  Frame-level sequencer in front of the GMII->AXI converter, in the gmii_rx_clk domain.

---
 rtl/gmii_rx_frame_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_frame_ctrl.sv
// gmii_rx_frame_ctrl
//   Frame-level sequencer ahead of the GMII->AXI converter (gmii_rx_clk domain).
//   Detects preamble/SFD, strips them, and admits or drops each whole frame at
//   SFD time. Forces an idle gap after every passed frame so the converter can
//   flush its partial word. Keeps saturating frame/drop/error counters.
// Ports
//   gmii_rx_clk  GMII receive clock          rst_n        async active-low reset
//   in_dv_i      GMII rx_dv                  in_er_i      GMII rx_er
//   in_rxd_i     GMII rxd                    enable_i     admit frames (sampled at SFD)
//   ds_ready_i   downstream ready (at SFD)   out_dv_o     gated rx_dv to converter
//   out_rxd_o    payload byte (DA..FCS)      busy_o       FSM not idle
//   frm_cnt_o    frames passed (incl. truncated)
//   drop_cnt_o   frames dropped by enable/ds_ready/gap rules
//   err_cnt_o    bad preamble, in_er in payload, or truncation
module gmii_rx_frame_ctrl #(
    parameter int unsigned MIN_PRE = 3,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             rst_n,
    input  logic             in_dv_i,
    input  logic             in_er_i,
    input  logic [7:0]       in_rxd_i,
    input  logic             enable_i,
    input  logic             ds_ready_i,
    output logic             out_dv_o,
    output logic [7:0]       out_rxd_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frm_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
    localparam int unsigned PRE_W = 3;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PASS,
        ST_GAP,
        ST_DROP
    } state_t;

    state_t             state_q;
    logic               dv_q;
    logic               armed_q;
    logic [PRE_W-1:0]   pre_cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               er_seen_q;
    logic               out_dv_q;
    logic [7:0]         out_rxd_q;
    logic               busy_q;
    logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               start_c;
    logic               pre_ok_c;
    logic               len_full_c;
    logic               frm_inc_c;
    logic               drop_inc_c;
    logic [1:0]         err_add_c;

    // armed_q blocks a frame that was already running when reset released
    assign start_c    = in_dv_i & ~dv_q & armed_q;
    assign pre_ok_c   = 32'(pre_cnt_q) >= MIN_PRE;
    assign len_full_c = (len_q == LEN_W'(MAX_LEN));

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       add);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(add);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Counter increment events; truncation and in_er can coincide, hence err +2
    always_comb begin
        frm_inc_c  = 1'b0;
        drop_inc_c = 1'b0;
        err_add_c  = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_c && in_rxd_i != PRE_BYTE) err_add_c = 2'd1;
            end
            ST_PRE: begin
                if (!in_dv_i) begin
                    err_add_c = 2'd1;
                end else if (in_rxd_i != PRE_BYTE) begin
                    if (in_rxd_i == SFD_BYTE && pre_ok_c) begin
                        drop_inc_c = ~(enable_i & ds_ready_i);
                    end else begin
                        err_add_c = 2'd1;
                    end
                end
            end
            ST_PASS: begin
                if (!in_dv_i) begin
                    frm_inc_c = 1'b1;
                end else if (len_full_c) begin
                    frm_inc_c = 1'b1;
                    err_add_c = 2'd1;
                end
                if (in_er_i && !er_seen_q) err_add_c = err_add_c + 2'd1;
            end
            ST_GAP: begin
                if (start_c) drop_inc_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign frm_cnt_d  = sat_add(frm_cnt_q,  {1'b0, frm_inc_c});
    assign drop_cnt_d = sat_add(drop_cnt_q, {1'b0, drop_inc_c});
    assign err_cnt_d  = sat_add(err_cnt_q,  err_add_c);

    // Frame sequencer; busy_q tracks whether the next state is non-idle
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dv_q       <= 1'b0;
            armed_q    <= 1'b0;
            pre_cnt_q  <= '0;
            len_q      <= '0;
            gap_cnt_q  <= '0;
            er_seen_q  <= 1'b0;
            out_dv_q   <= 1'b0;
            out_rxd_q  <= '0;
            busy_q     <= 1'b0;
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            dv_q       <= in_dv_i;
            if (!in_dv_i) armed_q <= 1'b1;
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
            out_dv_q   <= 1'b0;
            busy_q     <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        busy_q <= 1'b1;
                        if (in_rxd_i == PRE_BYTE) begin
                            state_q   <= ST_PRE;
                            pre_cnt_q <= PRE_W'(1);
                        end else begin
                            state_q   <= ST_DROP;
                        end
                    end
                end
                ST_PRE: begin
                    if (!in_dv_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (in_rxd_i == PRE_BYTE) begin
                        if (pre_cnt_q != '1) pre_cnt_q <= pre_cnt_q + 1'b1;
                    end else if (in_rxd_i == SFD_BYTE && pre_ok_c && enable_i && ds_ready_i) begin
                        state_q   <= ST_PASS;
                        len_q     <= '0;
                        er_seen_q <= 1'b0;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                ST_PASS: begin
                    out_rxd_q <= in_rxd_i;
                    if (in_er_i) er_seen_q <= 1'b1;
                    if (!in_dv_i) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                    end else if (len_full_c) begin
                        state_q <= ST_DROP;
                    end else begin
                        out_dv_q <= 1'b1;
                        len_q    <= len_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (start_c) begin
                        state_q <= ST_DROP;
                    end else if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_DROP: begin
                    if (!in_dv_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_dv_o   = out_dv_q;
    assign out_rxd_o  = out_rxd_q;
    assign busy_o     = busy_q;
    assign frm_cnt_o  = frm_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
